// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 128-bit-block main memory between the icache
// (read-only) and the dcache (read/write). One memory transaction at a time.
// Each requester is answered through its own busywait handshake.
//
// Ports:
//   CLK, RESET      clock (rising edge), async active-high reset
//   I_READ/I_ADDRESS/I_READDATA/I_BUSYWAIT
//                   icache block-read port
//   D_READ/D_WRITE/D_ADDRESS/D_WRITEDATA/D_READDATA/D_BUSYWAIT
//                   dcache block read / write-back port
//   MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA (registered),
//   MEM_READDATA/MEM_BUSYWAIT
//                   main memory port
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on
// contention. Without it, the dcache always wins contention.
module mem_arbiter (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         I_READ,
   input  logic [27:0]  I_ADDRESS,
   output logic [127:0] I_READDATA,
   output logic         I_BUSYWAIT,
   input  logic         D_READ,
   input  logic         D_WRITE,
   input  logic [27:0]  D_ADDRESS,
   input  logic [127:0] D_WRITEDATA,
   output logic [127:0] D_READDATA,
   output logic         D_BUSYWAIT,
   output logic         MEM_READ,
   output logic         MEM_WRITE,
   output logic [27:0]  MEM_ADDRESS,
   output logic [127:0] MEM_WRITEDATA,
   input  logic [127:0] MEM_READDATA,
   input  logic         MEM_BUSYWAIT
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   state_t        state_q, state_d;
   logic          grant_q, grant_d;      // 0 = icache, 1 = dcache
   logic          mem_read_q, mem_read_d;
   logic          mem_write_q, mem_write_d;
   logic [27:0]   mem_address_q, mem_address_d;
   logic [127:0]  mem_writedata_q, mem_writedata_d;
   logic [127:0]  i_readdata_q, i_readdata_d;
   logic [127:0]  d_readdata_q, d_readdata_d;

   logic i_req, d_req, win_d, any_req;

   assign i_req   = I_READ;
   assign d_req   = D_READ | D_WRITE;
   assign any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
   // rr_q remembers the port granted last; contention goes to the other one.
   logic rr_q, rr_d;

   assign win_d = (i_req & d_req) ? ~rr_q : d_req;

   always_comb begin
      rr_d = rr_q;
      if (state_q == ST_IDLE && any_req)
         rr_d = win_d;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) rr_q <= 1'b0;
      else       rr_q <= rr_d;
   end
`else
   assign win_d = d_req;
`endif

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (any_req) state_d = ST_ISSUE;
         // Memory needs one cycle to register the access before its
         // busywait is meaningful.
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (!MEM_BUSYWAIT) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output logic: busywait drops only in DONE, and only for the granted port.
   always_comb begin
      I_BUSYWAIT = i_req & ~(state_q == ST_DONE && !grant_q);
      D_BUSYWAIT = d_req & ~(state_q == ST_DONE &&  grant_q);
   end

   // Datapath: command is captured in IDLE and held until WAIT completes.
   always_comb begin
      grant_d         = grant_q;
      mem_read_d      = mem_read_q;
      mem_write_d     = mem_write_q;
      mem_address_d   = mem_address_q;
      mem_writedata_d = mem_writedata_q;
      i_readdata_d    = i_readdata_q;
      d_readdata_d    = d_readdata_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d       = win_d;
               mem_address_d = win_d ? D_ADDRESS : I_ADDRESS;
               // D_WRITE takes precedence when both dcache strobes are high.
               mem_write_d   = win_d & D_WRITE;
               mem_read_d    = ~(win_d & D_WRITE);
               if (win_d & D_WRITE)
                  mem_writedata_d = D_WRITEDATA;
            end
         end
         ST_WAIT: begin
            if (!MEM_BUSYWAIT) begin
               if (mem_read_q) begin
                  if (grant_q) d_readdata_d = MEM_READDATA;
                  else         i_readdata_d = MEM_READDATA;
               end
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         grant_q         <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
         i_readdata_q    <= '0;
         d_readdata_q    <= '0;
      end else begin
         grant_q         <= grant_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         mem_address_q   <= mem_address_d;
         mem_writedata_q <= mem_writedata_d;
         i_readdata_q    <= i_readdata_d;
         d_readdata_q    <= d_readdata_d;
      end
   end

   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDRESS   = mem_address_q;
   assign MEM_WRITEDATA = mem_writedata_q;
   assign I_READDATA    = i_readdata_q;
   assign D_READDATA    = d_readdata_q;

endmodule
